// File: rtl/pwr_seq_ctrl_pkg.sv
// Shared definitions for the platform power sequencer and its downstream consumers.
// The state codes are a fixed contract with the reset and DC-OK control blocks.
package pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_START        = 4'd0,
        ST_SBY          = 4'd1,
        ST_SBY_END      = 4'd2,
        ST_PS_ON        = 4'd3,
        ST_WORK_PG      = 4'd4,
        ST_ALL_PG       = 4'd5,
        ST_T5_RST       = 4'd6,
        ST_T5_RST_END   = 4'd7,
        ST_PCIE_RST_END = 4'd8,
        ST_ICH_DCOK     = 4'd9,
        ST_ICH_PG       = 4'd10,
        ST_CPU_DCOK     = 4'd11,
        ST_END          = 4'd12
    } state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int DLY_SBY_DEF  = 33;
    localparam int TMO_PG_DEF   = 16384;
    localparam int DLY_PG_DEF   = 3277;
    localparam int DLY_RST_DEF  = 33;
    localparam int DLY_DCOK_DEF = 66;

    function automatic logic is_legal(input logic [3:0] code);
        return code <= 4'd12;
    endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// Board-level signal bundle of the power sequencer: raw async status inputs in,
// registered enables and fault status out.
interface pwr_seq_ctrl_if;

    logic       i_sby_pg;
    logic       i_pwr_on_req;
    logic       i_pwr_off_req;
    logic       i_work_pg;
    logic       i_all_pg;
    logic       i_ich_pwrok;
    logic [3:0] o_ctrl_state;
    logic       o_ps_on;
    logic       o_pcie_rst_n;
    logic       o_ich_dcok;
    logic       o_cpu_dcok;
    logic       o_fault;
    logic [3:0] o_fault_code;

    // Level signals only, no handshake: inputs are sampled every clock through
    // synchronizers, outputs are held levels valid whenever reset is released.
    modport master (
        output i_sby_pg, i_pwr_on_req, i_pwr_off_req, i_work_pg, i_all_pg, i_ich_pwrok,
        input  o_ctrl_state, o_ps_on, o_pcie_rst_n, o_ich_dcok, o_cpu_dcok,
        input  o_fault, o_fault_code
    );

    modport slave (
        input  i_sby_pg, i_pwr_on_req, i_pwr_off_req, i_work_pg, i_all_pg, i_ich_pwrok,
        output o_ctrl_state, o_ps_on, o_pcie_rst_n, o_ich_dcok, o_cpu_dcok,
        output o_fault, o_fault_code
    );

endinterface

// File: rtl/pwr_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; both stages reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Main power-sequencing FSM on the 32.768 kHz standby clock: walks standby ->
// PSU on -> rail checks -> PCIe reset release -> DC-OK handoff, with fault capture.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DLY_SBY  = DLY_SBY_DEF,
    parameter int TMO_PG   = TMO_PG_DEF,
    parameter int DLY_PG   = DLY_PG_DEF,
    parameter int DLY_RST  = DLY_RST_DEF,
    parameter int DLY_DCOK = DLY_DCOK_DEF
) (
    input  logic          i_clk_32k,
    input  logic          i_rst_n,
    pwr_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] SBY_LAST  = CNT_W'(DLY_SBY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_PG - 1);
    localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(DLY_PG - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(DLY_RST - 1);
    localparam logic [CNT_W-1:0] DCOK_LAST = CNT_W'(DLY_DCOK - 1);

    logic sby_pg_s, pwr_on_req_s, pwr_off_req_s, work_pg_s, all_pg_s, ich_pwrok_s;

    sync_2ff u_sync_sby_pg  (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_sby_pg),      .o_q(sby_pg_s));
    sync_2ff u_sync_pwr_on  (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_pwr_on_req),  .o_q(pwr_on_req_s));
    sync_2ff u_sync_pwr_off (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_pwr_off_req), .o_q(pwr_off_req_s));
    sync_2ff u_sync_work_pg (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_work_pg),     .o_q(work_pg_s));
    sync_2ff u_sync_all_pg  (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_all_pg),      .o_q(all_pg_s));
    sync_2ff u_sync_ich_ok  (.i_clk(i_clk_32k), .i_rst_n(i_rst_n), .i_d(bus.i_ich_pwrok),   .o_q(ich_pwrok_s));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [3:0]       fault_code_q, fault_code_d;
    logic             ps_on_q, ps_on_d;
    logic             pcie_rst_n_q, pcie_rst_n_d;
    logic             ich_dcok_q, ich_dcok_d;
    logic             cpu_dcok_q, cpu_dcok_d;
    logic             awaited;
    logic             timeout;
    logic             pg_lost;

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_START;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 4'd0;
            ps_on_q      <= 1'b0;
            pcie_rst_n_q <= 1'b0;
            ich_dcok_q   <= 1'b0;
            cpu_dcok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            ps_on_q      <= ps_on_d;
            pcie_rst_n_q <= pcie_rst_n_d;
            ich_dcok_q   <= ich_dcok_d;
            cpu_dcok_q   <= cpu_dcok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            ST_PS_ON:    awaited = work_pg_s;
            ST_WORK_PG:  awaited = all_pg_s;
            ST_ICH_DCOK: awaited = ich_pwrok_s;
            default:     awaited = 1'b1;
        endcase
        timeout = (cnt_q == TMO_LAST) && !awaited;
        pg_lost = (state_q >= ST_ALL_PG) && (!work_pg_s || !all_pg_s);

        // Standby loss outranks everything; faults outrank a clean power-off.
        if (!is_legal(state_q) || (state_q != ST_START && !sby_pg_s)) begin
            state_d = ST_START;
        end else if (timeout || pg_lost) begin
            state_d      = ST_SBY;
            fault_d      = 1'b1;
            fault_code_d = state_q;
        end else if (pwr_off_req_s && state_q >= ST_SBY_END) begin
            state_d = ST_SBY;
        end else begin
            case (state_q)
                ST_START:        if (sby_pg_s)                       state_d = ST_SBY;
                ST_SBY:          if (pwr_on_req_s && !pwr_off_req_s) state_d = ST_SBY_END;
                ST_SBY_END:      if (cnt_q == SBY_LAST)              state_d = ST_PS_ON;
                ST_PS_ON:        if (work_pg_s)                      state_d = ST_WORK_PG;
                ST_WORK_PG:      if (all_pg_s)                       state_d = ST_ALL_PG;
                ST_ALL_PG:       if (cnt_q == PG_LAST)               state_d = ST_T5_RST;
                ST_T5_RST:       if (cnt_q == RST_LAST)              state_d = ST_T5_RST_END;
                ST_T5_RST_END:   if (cnt_q == RST_LAST)              state_d = ST_PCIE_RST_END;
                ST_PCIE_RST_END: if (cnt_q == RST_LAST)              state_d = ST_ICH_DCOK;
                ST_ICH_DCOK:     if (ich_pwrok_s)                    state_d = ST_ICH_PG;
                ST_ICH_PG:       if (cnt_q == DCOK_LAST)             state_d = ST_CPU_DCOK;
                ST_CPU_DCOK:     if (cnt_q == DCOK_LAST)             state_d = ST_END;
                default:         state_d = state_q;
            endcase
        end

        // A fresh power-on attempt forgets the previous fault.
        if (state_d == ST_SBY_END && state_q != ST_SBY_END) begin
            fault_d      = 1'b0;
            fault_code_d = 4'd0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        ps_on_d      = (state_d >= ST_PS_ON);
        pcie_rst_n_d = (state_d >= ST_PCIE_RST_END);
        ich_dcok_d   = (state_d >= ST_ICH_DCOK);
        cpu_dcok_d   = (state_d >= ST_CPU_DCOK);
    end

    assign bus.o_ctrl_state = state_q;
    assign bus.o_ps_on      = ps_on_q;
    assign bus.o_pcie_rst_n = pcie_rst_n_q;
    assign bus.o_ich_dcok   = ich_dcok_q;
    assign bus.o_cpu_dcok   = cpu_dcok_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_code = fault_code_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: nominal power-on, timeouts, faults, standby
// loss, power-off and asynchronous reset, with hand-computed expectations.
module tb_pwr_seq_ctrl;
    import pwr_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pwr_seq_ctrl_if bus ();

    pwr_seq_ctrl dut (
        .i_clk_32k(clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // {ps_on, pcie_rst_n, ich_dcok, cpu_dcok} expected for a state code
    function automatic logic [3:0] exp_outs(input logic [3:0] code);
        return {code >= 4'd3 && code <= 4'd12, code >= 4'd8 && code <= 4'd12,
                code >= 4'd9 && code <= 4'd12, code >= 4'd11 && code <= 4'd12};
    endfunction

    function automatic logic [3:0] act_outs();
        return {bus.o_ps_on, bus.o_pcie_rst_n, bus.o_ich_dcok, bus.o_cpu_dcok};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_code(input logic [3:0] code, input int budget, output int n);
        n = 0;
        while (bus.o_ctrl_state !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic dwell(input int budget, output int n);
        logic [3:0] c;
        c = bus.o_ctrl_state;
        n = 0;
        while (bus.o_ctrl_state === c && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_sby_pg = 1'b0; bus.i_pwr_on_req = 1'b0; bus.i_pwr_off_req = 1'b0;
        bus.i_work_pg = 1'b0; bus.i_all_pg = 1'b0; bus.i_ich_pwrok = 1'b0;
        tick(2);
        n_vec++;
        if ({bus.o_ctrl_state, act_outs(), bus.o_fault, bus.o_fault_code} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_values: got state=%0d outs=%b fault=%b code=%0d, want all 0",
                     bus.o_ctrl_state, act_outs(), bus.o_fault, bus.o_fault_code);
        end
        rst_n = 1'b1;
        tick(4);
        n_vec++;
        if (bus.o_ctrl_state !== 4'd0) begin
            n_err++;
            $display("FAIL start_hold: got state=%0d, want 0", bus.o_ctrl_state);
        end
    endtask

    task automatic test_nominal();
        int n;
        int codes[4]  = '{5, 6, 7, 8};
        int dwells[4] = '{3277, 33, 33, 33};
        bus.i_sby_pg = 1'b1;
        wait_code(4'd1, 10, n);
        n_vec++;
        if (n !== 3) begin n_err++; $display("FAIL sby_latency: got %0d cycles, want 3", n); end
        bus.i_pwr_on_req = 1'b1;
        wait_code(4'd2, 10, n);
        n_vec++;
        if (n !== 3) begin n_err++; $display("FAIL pwr_on_latency: got %0d cycles, want 3", n); end
        dwell(50, n);
        n_vec++;
        if (n !== 33 || bus.o_ctrl_state !== 4'd3 || act_outs() !== 4'b1000) begin
            n_err++;
            $display("FAIL sby_end_dwell: got dwell=%0d state=%0d outs=%b, want 33/3/1000",
                     n, bus.o_ctrl_state, act_outs());
        end
        tick(99);
        bus.i_work_pg = 1'b1;
        dwell(10, n);
        n_vec++;
        if (n !== 3 || bus.o_ctrl_state !== 4'd4) begin
            n_err++;
            $display("FAIL work_pg_arrival: got tail=%0d state=%0d, want 3/4", n, bus.o_ctrl_state);
        end
        tick(49);
        bus.i_all_pg = 1'b1;
        dwell(10, n);
        n_vec++;
        if (n !== 3 || bus.o_ctrl_state !== 4'd5) begin
            n_err++;
            $display("FAIL all_pg_arrival: got tail=%0d state=%0d, want 3/5", n, bus.o_ctrl_state);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({bus.o_ctrl_state, act_outs()} !== {4'(codes[i]), exp_outs(4'(codes[i]))}) begin
                n_err++;
                $display("FAIL entry_%0d: got state=%0d outs=%b, want outs=%b",
                         codes[i], bus.o_ctrl_state, act_outs(), exp_outs(4'(codes[i])));
            end
            dwell(dwells[i] + 10, n);
            n_vec++;
            if (n !== dwells[i] || bus.o_ctrl_state !== 4'(codes[i] + 1)) begin
                n_err++;
                $display("FAIL dwell_%0d: got dwell=%0d next=%0d, want %0d/%0d",
                         codes[i], n, bus.o_ctrl_state, dwells[i], codes[i] + 1);
            end
        end
        n_vec++;
        if (act_outs() !== 4'b1110) begin
            n_err++;
            $display("FAIL entry_9: got outs=%b, want 1110", act_outs());
        end
        tick(19);
        bus.i_ich_pwrok = 1'b1;
        dwell(10, n);
        n_vec++;
        if (n !== 3 || bus.o_ctrl_state !== 4'd10) begin
            n_err++;
            $display("FAIL ich_pwrok_arrival: got tail=%0d state=%0d, want 3/10", n, bus.o_ctrl_state);
        end
        for (int c = 10; c <= 11; c++) begin
            n_vec++;
            if (act_outs() !== exp_outs(4'(c))) begin
                n_err++;
                $display("FAIL entry_%0d: got outs=%b, want %b", c, act_outs(), exp_outs(4'(c)));
            end
            dwell(80, n);
            n_vec++;
            if (n !== 66 || bus.o_ctrl_state !== 4'(c + 1)) begin
                n_err++;
                $display("FAIL dwell_%0d: got dwell=%0d next=%0d, want 66/%0d", c, n, bus.o_ctrl_state, c + 1);
            end
        end
        n_vec++;
        if ({act_outs(), bus.o_fault} !== 5'b11110) begin
            n_err++;
            $display("FAIL end_outputs: got outs=%b fault=%b, want 1111/0", act_outs(), bus.o_fault);
        end
    endtask

    task automatic test_pg_loss_end();
        int n;
        bus.i_pwr_on_req = 1'b0;
        tick(3);
        bus.i_all_pg = 1'b0;
        wait_code(4'd1, 10, n);
        n_vec++;
        if (n !== 3 || {act_outs(), bus.o_fault, bus.o_fault_code} !== {4'b0000, 1'b1, 4'd12}) begin
            n_err++;
            $display("FAIL pg_loss_end: got lat=%0d outs=%b fault=%b code=%0d, want 3/0000/1/12",
                     n, act_outs(), bus.o_fault, bus.o_fault_code);
        end
        tick(5);
        n_vec++;
        if (bus.o_ctrl_state !== 4'd1 || bus.o_fault !== 1'b1 || bus.o_fault_code !== 4'd12) begin
            n_err++;
            $display("FAIL fault_sticky: got state=%0d fault=%b code=%0d, want 1/1/12",
                     bus.o_ctrl_state, bus.o_fault, bus.o_fault_code);
        end
    endtask

    task automatic test_pson_timeout();
        int n;
        bus.i_work_pg = 1'b0;
        bus.i_pwr_on_req = 1'b1;
        wait_code(4'd2, 10, n);
        n_vec++;
        if (n !== 3 || bus.o_fault !== 1'b0 || bus.o_fault_code !== 4'd0) begin
            n_err++;
            $display("FAIL fault_clear_12: got lat=%0d fault=%b code=%0d, want 3/0/0", n, bus.o_fault, bus.o_fault_code);
        end
        dwell(50, n);
        bus.i_pwr_on_req = 1'b0;
        dwell(16400, n);
        n_vec++;
        if (n !== 16384 || bus.o_ctrl_state !== 4'd1) begin
            n_err++;
            $display("FAIL pson_timeout_dwell: got dwell=%0d state=%0d, want 16384/1", n, bus.o_ctrl_state);
        end
        n_vec++;
        if ({bus.o_ps_on, bus.o_fault, bus.o_fault_code} !== {1'b0, 1'b1, 4'd3}) begin
            n_err++;
            $display("FAIL pson_timeout_fault: got ps_on=%b fault=%b code=%0d, want 0/1/3",
                     bus.o_ps_on, bus.o_fault, bus.o_fault_code);
        end
        bus.i_pwr_on_req = 1'b1;
        wait_code(4'd2, 10, n);
        n_vec++;
        if (n !== 3 || bus.o_fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_clear_3: got lat=%0d fault=%b, want 3/0", n, bus.o_fault);
        end
    endtask

    task automatic test_timeout_race();
        int n;
        dwell(50, n);
        n_vec++;
        if (n !== 33 || bus.o_ctrl_state !== 4'd3) begin
            n_err++;
            $display("FAIL race_sby_end: got dwell=%0d state=%0d, want 33/3", n, bus.o_ctrl_state);
        end
        tick(16381);
        bus.i_work_pg = 1'b1;
        dwell(10, n);
        n_vec++;
        if (n !== 3 || bus.o_ctrl_state !== 4'd4 || bus.o_fault !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_race: got tail=%0d state=%0d fault=%b, want 3/4/0",
                     n, bus.o_ctrl_state, bus.o_fault);
        end
    endtask

    task automatic test_sby_loss();
        int n;
        bus.i_all_pg = 1'b1;
        wait_code(4'd7, 4000, n);
        n_vec++;
        if (bus.o_ctrl_state !== 4'd7) begin
            n_err++;
            $display("FAIL reach_7: got state=%0d, want 7", bus.o_ctrl_state);
        end
        bus.i_sby_pg = 1'b0;
        bus.i_pwr_off_req = 1'b1;
        wait_code(4'd0, 10, n);
        n_vec++;
        if (n !== 3 || {act_outs(), bus.o_fault} !== 5'b00000) begin
            n_err++;
            $display("FAIL sby_loss: got lat=%0d state=%0d outs=%b fault=%b, want 3/0/0000/0",
                     n, bus.o_ctrl_state, act_outs(), bus.o_fault);
        end
    endtask

    task automatic test_power_off();
        int n;
        bus.i_sby_pg = 1'b1;
        bus.i_pwr_off_req = 1'b0;
        wait_code(4'd12, 5000, n);
        n_vec++;
        if (bus.o_ctrl_state !== 4'd12) begin
            n_err++;
            $display("FAIL reach_end: got state=%0d, want 12", bus.o_ctrl_state);
        end
        bus.i_pwr_off_req = 1'b1;
        wait_code(4'd1, 10, n);
        n_vec++;
        if (n !== 3 || {act_outs(), bus.o_fault} !== 5'b00000) begin
            n_err++;
            $display("FAIL power_off: got lat=%0d state=%0d outs=%b fault=%b, want 3/1/0000/0",
                     n, bus.o_ctrl_state, act_outs(), bus.o_fault);
        end
        bus.i_pwr_off_req = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        wait_code(4'd12, 5000, n);
        n_vec++;
        if (bus.o_ctrl_state !== 4'd12) begin
            n_err++;
            $display("FAIL reach_end_2: got state=%0d, want 12", bus.o_ctrl_state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.o_ctrl_state, act_outs(), bus.o_fault, bus.o_fault_code} !== 13'd0) begin
            n_err++;
            $display("FAIL async_reset: got state=%0d outs=%b fault=%b code=%0d, want all 0",
                     bus.o_ctrl_state, act_outs(), bus.o_fault, bus.o_fault_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_nominal();
        test_pg_loss_end();
        test_pson_timeout();
        test_timeout_race();
        test_sby_loss();
        test_power_off();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
